rram_instr_sequencer: RTL and testbench
=======================================

# rram_instr_sequencer

Instruction sequencer for the RRAM controller's instruction memory. It loads a host program into the instruction FIFO/RAM through its write port and, on start, fetches instructions from a start address. It executes NOP/JUMP/HALT internally and issues RRAM operations (READ/SET/RESET/FORM) to the pulse engine over a valid/ready handshake. It sits between the host register interface, the instruction memory write/read chip-select ports, and the operation engine.

## Interface
- DATA_WIDTH, 32: instruction width; opcode in [31:28], operand in [27:0]
- ADDR_WIDTH, 7: instruction memory address width
- RAM_DEPTH, 64: number of valid instruction addresses, 0..RAM_DEPTH-1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  run request; honoured only when not busy
- abort  in  1  stop request; forces IDLE on the next edge from any state
- start_pc  in  ADDR_WIDTH  first fetch address, sampled with start
- host_wr_valid / host_wr_ready  in / out  1  program-load handshake
- host_wr_addr  in  ADDR_WIDTH  program-load address
- host_wr_data  in  DATA_WIDTH  program-load word
- im_wr_cs, im_wr_en  out  1  memory write chip select and enable
- im_wr_addr  out  ADDR_WIDTH  memory write address
- im_wr_data  out  DATA_WIDTH  memory write data
- im_rd_cs, im_rd_en  out  1  memory read chip select and enable
- im_rd_addr  out  ADDR_WIDTH  memory read address
- im_rd_data  in  DATA_WIDTH  memory registered read data
- issue_valid / issue_ready  out / in  1  operation handshake to the engine
- issue_opcode  out  4  operation opcode
- issue_operand  out  28  operation operand (cell address/config)
- busy  out  1  high in any state except IDLE, DONE, ERROR
- done  out  1  high while in DONE
- error  out  1  high while in ERROR
- err_code  out  2  0 none, 1 illegal opcode, 2 PC overrun, 3 bad jump target
- pc  out  ADDR_WIDTH  current program counter

## Operation
- Opcodes:
  - 0 NOP
  - 1 READ
  - 2 SET
  - 3 RESET
  - 4 FORM
  - 8 JUMP, target = operand[ADDR_WIDTH-1:0]
  - F HALT
  - all others illegal
- States: IDLE, WR1, WR2, FETCH1, FETCH2, DECODE, ISSUE, DONE, ERROR.
- IDLE, DONE and ERROR are "not busy". In these states host_wr_ready=1.
- Priority when not busy:
  - host_wr_valid&&host_wr_ready goes to WR1; the write latches addr/data.
  - Otherwise start goes to FETCH1 with pc<=start_pc.
  - If both arrive together, the write wins and start is dropped.
- WR1 and WR2:
  - im_wr_cs=im_wr_en=1 with the latched addr/data held stable for both cycles. The memory registers its pointer.
  - WR1 always goes to WR2.
  - WR2 returns to IDLE.
  - done, error and err_code clear on entering WR1.
- FETCH1 and FETCH2:
  - im_rd_cs=im_rd_en=1, im_rd_addr=pc for both cycles.
  - FETCH1 always goes to FETCH2, and FETCH2 always goes to DECODE.
- DECODE: im_rd_data is valid in this cycle and is latched into instr_q.
  - NOP: pc+1, then FETCH1.
  - JUMP with target<RAM_DEPTH: pc<=target, then FETCH1. Otherwise ERROR, code 3.
  - HALT: DONE, pc unchanged.
  - READ/SET/RESET/FORM: ISSUE.
  - Illegal opcode: ERROR, code 1.
- PC overrun: NOP, or a handshake completing, at pc==RAM_DEPTH-1 goes to ERROR with code 2. No wrap.
- ISSUE:
  - issue_valid=1, and issue_opcode/operand come from instr_q.
  - These outputs hold stable until issue_ready.
  - On the handshake edge: pc+1, then FETCH1.
- abort takes priority over every transition. It goes to IDLE and clears done/error/err_code.
  - A write in flight (WR1/WR2) completes its current cycle only; the write is not guaranteed.
- Memory enables are never asserted outside WR1/WR2 (write) or FETCH1/FETCH2 (read).

## Timing
- Reset: state IDLE. All outputs are 0, including issue_valid, busy, done, error, err_code, pc and im_* strobes, except host_wr_ready=1.
- start sampled at edge t:
  - FETCH1 in cycle t+1 and FETCH2 in t+2.
  - DECODE in t+3.
  - issue_valid high at t+4 at the earliest.
- Throughput: 4 cycles per issued instruction at zero engine stall; 3 cycles per NOP/JUMP.
- Program load: one word per 3 cycles (WR1, WR2, IDLE).
- issue_valid never drops without a handshake, except on abort or rst.
- rst mid-operation gives IDLE on the next edge. Memory contents are not touched.

## Configuration
- IMSEQ_JUMP_EN defined: JUMP is decoded as above.
- IMSEQ_JUMP_EN undefined: opcode 8 is illegal, giving ERROR with err_code 1. The jump-target comparator is removed.

## Test plan
- Basic program: load 0:SET 0x0000123, 1:READ 0x0000123, 2:HALT; start_pc=0, issue_ready tied 1 -> two issues:
  - (2,0x123) then (1,0x123).
  - done=1, pc=2, busy=0.
- Engine stall: issue_ready held 0 for 5 cycles on a SET -> issue_valid/opcode/operand stable for all 5 cycles; single handshake; pc advances once.
- Jump: program 0:JUMP 5, 5:RESET 0x7, 6:HALT -> one issue (3,0x7), done with pc=6.
  - Same program with JUMP 70 -> error=1, err_code=3.
  - Without IMSEQ_JUMP_EN -> err_code=1.
- Overrun and illegal:
  - NOP at address 63 with start_pc=63 -> err_code=2.
  - Opcode 0x5 at start_pc -> err_code=1, no issue_valid.
- Abort and reset: abort during ISSUE -> IDLE next cycle, issue_valid=0, busy=0.
  - rst during FETCH2 -> all outputs at reset values next cycle.
  - A following start re-runs correctly.
- Write/start collision: host_wr_valid and start on the same edge in IDLE -> WR1/WR2 strobes with correct addr/data, start ignored, state IDLE after.

Source files
------------

// File: rtl/rram_instr_sequencer.sv
// Instruction sequencer: loads a host program into instruction memory, then fetches,
// decodes and issues RRAM operations. Define IMSEQ_JUMP_EN to enable the JUMP opcode.
module rram_instr_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RAM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic                  host_wr_valid,
    output logic                  host_wr_ready,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    output logic                  im_wr_cs,
    output logic                  im_wr_en,
    output logic [ADDR_WIDTH-1:0] im_wr_addr,
    output logic [DATA_WIDTH-1:0] im_wr_data,
    output logic                  im_rd_cs,
    output logic                  im_rd_en,
    output logic [ADDR_WIDTH-1:0] im_rd_addr,
    input  logic [DATA_WIDTH-1:0] im_rd_data,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [3:0]            issue_opcode,
    output logic [27:0]           issue_operand,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WR1    = 4'd1;
    localparam logic [3:0] S_WR2    = 4'd2;
    localparam logic [3:0] S_FETCH1 = 4'd3;
    localparam logic [3:0] S_FETCH2 = 4'd4;
    localparam logic [3:0] S_DECODE = 4'd5;
    localparam logic [3:0] S_ISSUE  = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERROR  = 4'd8;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_READ  = 4'h1;
    localparam logic [3:0] OP_SET   = 4'h2;
    localparam logic [3:0] OP_RESET = 4'h3;
    localparam logic [3:0] OP_FORM  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;
`ifdef IMSEQ_JUMP_EN
    localparam logic [3:0]          OP_JUMP = 4'h8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(RAM_DEPTH);
`endif

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TARGET  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [3:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            err_q, err_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;

    logic                  idle_like;
    logic                  in_wr;
    logic                  in_fetch;
    logic [3:0]            dec_op;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    assign in_wr     = (state_q == S_WR1) || (state_q == S_WR2);
    assign in_fetch  = (state_q == S_FETCH1) || (state_q == S_FETCH2);
    assign dec_op    = im_rd_data[DATA_WIDTH-1 -: 4];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        err_d     = err_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        instr_d   = instr_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // A program-load write beats a simultaneous start, which is dropped.
                if (host_wr_valid) begin
                    state_d   = S_WR1;
                    wr_addr_d = host_wr_addr;
                    wr_data_d = host_wr_data;
                    err_d     = ERR_NONE;
                end else if (start) begin
                    state_d = S_FETCH1;
                    pc_d    = start_pc;
                    err_d   = ERR_NONE;
                end
            end
            S_WR1:    state_d = S_WR2;
            S_WR2:    state_d = S_IDLE;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                instr_d = im_rd_data;
                case (dec_op)
                    OP_NOP: begin
                        if (pc_q == LAST_PC) begin
                            state_d = S_ERROR;
                            err_d   = ERR_OVERRUN;
                        end else begin
                            pc_d    = pc_q + ADDR_WIDTH'(1);
                            state_d = S_FETCH1;
                        end
                    end
`ifdef IMSEQ_JUMP_EN
                    OP_JUMP: begin
                        if ({1'b0, im_rd_data[ADDR_WIDTH-1:0]} < DEPTH_W) begin
                            pc_d    = im_rd_data[ADDR_WIDTH-1:0];
                            state_d = S_FETCH1;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = ERR_TARGET;
                        end
                    end
`endif
                    OP_HALT: state_d = S_DONE;
                    OP_READ, OP_SET, OP_RESET, OP_FORM: state_d = S_ISSUE;
                    default: begin
                        state_d = S_ERROR;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    if (pc_q == LAST_PC) begin
                        state_d = S_ERROR;
                        err_d   = ERR_OVERRUN;
                    end else begin
                        pc_d    = pc_q + ADDR_WIDTH'(1);
                        state_d = S_FETCH1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            err_d   = ERR_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            err_q     <= ERR_NONE;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            instr_q   <= instr_d;
        end
    end

    assign host_wr_ready = idle_like;
    assign busy          = !idle_like;
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERROR);
    assign err_code      = err_q;
    assign pc            = pc_q;

    assign im_wr_cs      = in_wr;
    assign im_wr_en      = in_wr;
    assign im_wr_addr    = in_wr ? wr_addr_q : '0;
    assign im_wr_data    = in_wr ? wr_data_q : '0;
    assign im_rd_cs      = in_fetch;
    assign im_rd_en      = in_fetch;
    assign im_rd_addr    = in_fetch ? pc_q : '0;

    assign issue_valid   = (state_q == S_ISSUE);
    assign issue_opcode  = issue_valid ? instr_q[DATA_WIDTH-1 -: 4] : '0;
    assign issue_operand = issue_valid ? instr_q[27:0] : '0;

endmodule

// File: tb/tb_rram_instr_sequencer.sv
// Scoreboard bench for rram_instr_sequencer: directed programs with a behavioural
// instruction memory; issued operations are checked by an independent monitor.
module tb_rram_instr_sequencer;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [AW-1:0] start_pc;
    logic          host_wr_valid, host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          im_wr_cs, im_wr_en;
    logic [AW-1:0] im_wr_addr;
    logic [DW-1:0] im_wr_data;
    logic          im_rd_cs, im_rd_en;
    logic [AW-1:0] im_rd_addr;
    logic [DW-1:0] im_rd_data;
    logic          issue_valid, issue_ready;
    logic [3:0]    issue_opcode;
    logic [27:0]   issue_operand;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [AW-1:0] pc;

    int errors = 0;
    int checks = 0;
    int issues = 0;
    logic [31:0] exp_q[$];
    logic [DW-1:0] mem [0:127];

    always #5 clk = ~clk;

    rram_instr_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .start_pc(start_pc),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .im_wr_cs(im_wr_cs), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
        .im_wr_data(im_wr_data), .im_rd_cs(im_rd_cs), .im_rd_en(im_rd_en),
        .im_rd_addr(im_rd_addr), .im_rd_data(im_rd_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_operand(issue_operand),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .pc(pc)
    );

    // Instruction memory: registered read, data visible two edges after the address.
    always @(posedge clk) begin
        if (im_wr_cs && im_wr_en) mem[im_wr_addr] <= im_wr_data;
        if (im_rd_cs && im_rd_en) im_rd_data <= mem[im_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (issue_valid && issue_ready) begin
            issues++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got 0x%0h expected none", {issue_opcode, issue_operand});
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({issue_opcode, issue_operand} !== e) begin
                    errors++;
                    $display("FAIL issue_op: got 0x%0h expected 0x%0h", {issue_opcode, issue_operand}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        tick();
        host_wr_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic run(input logic [AW-1:0] p, output int first_issue);
        int n;
        first_issue = 0;
        start       = 1'b1;
        start_pc    = p;
        tick();
        start = 1'b0;
        n     = 1;
        while (!(done || error) && n < 300) begin
            if (issue_valid && first_issue == 0) first_issue = n;
            tick();
            n++;
        end
        checks++;
        if (!(done || error)) begin
            errors++;
            $display("FAIL run_timeout: got busy=%0b expected done or error", busy);
        end
    endtask

    task automatic wait_issue(input string name);
        int n;
        n = 0;
        while (!issue_valid && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(issue_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int fi;
        int n0;
        logic stable;
        logic [31:0] snap;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_pc = '0;
        host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        issue_ready = 1'b1;
        tick(); tick();
        chk("reset_flags", {21'd0, issue_valid, busy, done, error, err_code, im_wr_cs, im_wr_en,
                            im_rd_cs, im_rd_en, host_wr_ready}, 32'h1);
        chk("reset_pc", 32'(pc), 32'd0);
        rst = 1'b0;
        tick();

        // Basic program: SET then READ then HALT
        load(7'd0, 32'h2000_0123);
        load(7'd1, 32'h1000_0123);
        load(7'd2, 32'hF000_0000);
        exp_q.push_back(32'h2000_0123);
        exp_q.push_back(32'h1000_0123);
        run(7'd0, fi);
        chk("basic_first_issue_latency", 32'(fi), 32'd4);
        chk("basic_done", {30'd0, done, busy}, 32'h2);
        chk("basic_pc", 32'(pc), 32'd2);
        chk("basic_issue_count", 32'(issues), 32'd2);

        // Engine stall for 5 cycles on a SET
        load(7'd0, 32'h2000_0055);
        load(7'd1, 32'hF000_0000);
        issue_ready = 1'b0;
        exp_q.push_back(32'h2000_0055);
        n0 = issues;
        start = 1'b1; start_pc = 7'd0;
        tick();
        start = 1'b0;
        wait_issue("stall_reach_issue");
        snap   = {issue_opcode, issue_operand};
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!issue_valid || {issue_opcode, issue_operand} !== snap || pc !== 7'd0) stable = 1'b0;
            tick();
        end
        chk("stall_stable", 32'(stable), 32'd1);
        chk("stall_snapshot", snap, 32'h2000_0055);
        issue_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("stall_done_pc", {24'd0, done, pc}, {24'd0, 1'b1, 7'd1});
        chk("stall_single_handshake", 32'(issues - n0), 32'd1);

        // Jump to an in-range target, then an out-of-range target
        load(7'd0, 32'h8000_0005);
        load(7'd5, 32'h3000_0007);
        load(7'd6, 32'hF000_0000);
`ifdef IMSEQ_JUMP_EN
        exp_q.push_back(32'h3000_0007);
        run(7'd0, fi);
        chk("jump_done_pc", {24'd0, done, pc}, {24'd0, 1'b1, 7'd6});
        load(7'd0, 32'h8000_0046);
        run(7'd0, fi);
        chk("jump_bad_target", {29'd0, error, err_code}, {29'd0, 1'b1, 2'd3});
`else
        run(7'd0, fi);
        chk("jump_disabled_illegal", {29'd0, error, err_code}, {29'd0, 1'b1, 2'd1});
        chk("jump_disabled_pc", 32'(pc), 32'd0);
`endif

        // PC overrun on a NOP at the last address
        load(7'd63, 32'h0000_0000);
        run(7'd63, fi);
        chk("overrun_err", {29'd0, error, err_code}, {29'd0, 1'b1, 2'd2});
        chk("overrun_pc", 32'(pc), 32'd63);

        // Illegal opcode 0x5
        load(7'd10, 32'h5000_0000);
        n0 = issues;
        run(7'd10, fi);
        chk("illegal_err", {29'd0, error, err_code}, {29'd0, 1'b1, 2'd1});
        chk("illegal_no_issue", 32'(fi + issues - n0), 32'd0);

        // Abort while holding an issue
        load(7'd0, 32'h2000_0009);
        load(7'd1, 32'hF000_0000);
        chk("load_clears_error", {30'd0, error, done}, 32'd0);
        issue_ready = 1'b0;
        start = 1'b1; start_pc = 7'd0;
        tick();
        start = 1'b0;
        wait_issue("abort_reach_issue");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {29'd0, issue_valid, busy, host_wr_ready}, 32'h1);
        issue_ready = 1'b1;

        // Reset during FETCH2, then a clean re-run
        start = 1'b1; start_pc = 7'd0;
        tick();
        start = 1'b0;
        tick();
        chk("fetch2_strobes", {29'd0, im_rd_cs, im_rd_en, busy}, 32'h7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_flags", {21'd0, issue_valid, busy, done, error, err_code, im_wr_cs, im_wr_en,
                              im_rd_cs, im_rd_en, host_wr_ready}, 32'h1);
        chk("rst_mid_pc", 32'(pc), 32'd0);
        exp_q.push_back(32'h2000_0009);
        run(7'd0, fi);
        chk("rerun_done_pc", {24'd0, done, pc}, {24'd0, 1'b1, 7'd1});

        // Write and start on the same edge: write wins
        host_wr_valid = 1'b1; host_wr_addr = 7'd20; host_wr_data = 32'hDEAD_BEEF;
        start = 1'b1; start_pc = 7'd20;
        tick();
        host_wr_valid = 1'b0; start = 1'b0;
        chk("coll_wr1", {28'd0, im_wr_cs, im_wr_en, im_rd_cs, done}, 32'hC);
        chk("coll_wr1_addr", 32'(im_wr_addr), 32'd20);
        chk("coll_wr1_data", im_wr_data, 32'hDEAD_BEEF);
        tick();
        chk("coll_wr2", {28'd0, im_wr_cs, im_wr_en, im_rd_cs, done}, 32'hC);
        chk("coll_wr2_data", {im_wr_data[31:7], im_wr_addr}, {25'h1BD5B7D, 7'd20});
        tick();
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (busy || im_rd_cs || im_wr_cs) stable = 1'b0;
            tick();
        end
        chk("coll_start_dropped", 32'(stable), 32'd1);
        chk("coll_mem_written", mem[20], 32'hDEAD_BEEF);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
